binary_to_bcd: RTL and testbench
================================

// Module: binary_to_bcd
// PURPOSE
//  Registered unsigned-binary to packed-BCD converter for display/readout paths.
//  Converts a WIDTH-bit unsigned input into DIGITS BCD nibbles, least-significant digit in b[3:0].
//  The core is a fully unrolled shift-add-3 (double-dabble) network, followed by one output register.
// PARAMETERS
//  WIDTH   8  binary input width in bits.
//  DIGITS  3  number of BCD output digits.
//             Must satisfy 10**DIGITS > 2**WIDTH - 1 (default: 255 fits in 3 digits).
// PORTS
//  clk    in   1           rising-edge clock; the only clock.
//  rst_n  in   1           asynchronous, active-low reset.
//  a      in   WIDTH       unsigned binary value.
//  b      out  4*DIGITS    packed BCD: b[4k+3:4k] holds decimal digit k (k=0 is units).
// BEHAVIOUR
//  - Reset: while rst_n=0, b=0 immediately (asynchronous assert).
//    Release is synchronous to clk. First update occurs on the first rising edge after release.
//  - Conversion: at each rising edge, b <= BCD(a), i.e. digit k = (a / 10**k) % 10.
//    Latency is exactly 1 cycle; throughput is 1 conversion per cycle.
//  - Arithmetic: double-dabble over WIDTH iterations, unrolled combinationally.
//    Before each shift, any BCD nibble >= 5 gets +3. The result is purely a function of a.
//    There is no carry-out, saturation or error flag.
//  - Unused high digits are driven 0 (e.g. a=42 -> b[11:8]=0).
//  - Every nibble of b is always in the range 0..9; values 10..15 never appear on b.
//  - Boundary: a=0 -> all digits 0; a=2**WIDTH-1 -> full decimal value (255 -> 12'h255).
//  - Reset mid-operation: b clears at once; the value in flight is discarded.
//    After release, b reflects the a sampled at the first clock edge.
//  - a may change arbitrarily between edges; only the value at the clock edge matters.
// CONFIGURATION
//  BINARY_TO_BCD_HANDSHAKE_EN
//   Defined: adds ports in_valid (in, 1) and out_valid (out, 1).
//    - b updates only on edges where in_valid=1; otherwise b holds its value.
//    - out_valid <= in_valid on every edge. out_valid resets to 0.
//    - out_valid=1 marks the cycle in which b holds the conversion of the a sampled with in_valid.
//   Undefined: no extra ports; b updates on every clock edge as described above.
// TESTING
//  - Reset: assert rst_n=0 with a=8'd200 -> b=12'h000 immediately, and stays 0 across clock edges while held.
//  - Digit boundaries: a=9,10,99,100 -> one cycle later b=12'h009,12'h010,12'h099,12'h100.
//  - Extremes: a=0 -> b=12'h000; a=255 -> b=12'h255.
//  - Exhaustive sweep: a=0..255, one value per cycle.
//    Compare b against (a%10) | ((a/10%10)<<4) | ((a/100)<<8) one cycle later; also check every nibble <=9.
//  - Reset mid-stream: while streaming, pull rst_n low between edges.
//    Expect b=0 at once; after release, the first edge with a=8'd37 gives b=12'h037.
//  - With BINARY_TO_BCD_HANDSHAKE_EN: in_valid=1 with a=123, then in_valid=0 with a=45.
//    Expect b=12'h123 with out_valid=1, then b held at 12'h123 with out_valid=0.

Source files
------------

// File: rtl/binary_to_bcd.sv
// binary_to_bcd: registered unsigned-binary to packed-BCD converter.
// A fully unrolled shift-add-3 (double-dabble) network feeds one output register.
// Digit k of the result sits in b[4k+3:4k]; k=0 is the units digit.
// Optional feature macro: BINARY_TO_BCD_HANDSHAKE_EN adds in_valid/out_valid.
//   Defined  : b loads only when in_valid=1, out_valid follows in_valid by one edge.
//   Undefined: b loads the conversion of a on every rising edge.
module binary_to_bcd #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef BINARY_TO_BCD_HANDSHAKE_EN
   input  logic                in_valid,
   output logic                out_valid,
`endif
   input  logic [WIDTH-1:0]    a,
   output logic [4*DIGITS-1:0] b
);

   localparam int BW = 4 * DIGITS;

   logic [BW-1:0] bcd_s;

   // Double-dabble: before each shift, every nibble holding 5..9 gets +3 so
   // the following shift carries correctly into the next decimal digit.
   // DIGITS is sized so the top bit shifted out of the accumulator is always 0.
   function automatic logic [BW-1:0] double_dabble(input logic [WIDTH-1:0] bin);
      logic [BW-1:0] acc;
      acc = {BW{1'b0}};
      for (int i = WIDTH - 1; i >= 0; i--) begin
         for (int k = 0; k < DIGITS; k++) begin
            if (acc[4*k +: 4] >= 4'd5) begin
               acc[4*k +: 4] = acc[4*k +: 4] + 4'd3;
            end else begin
               acc[4*k +: 4] = acc[4*k +: 4];
            end
         end
         acc = {acc[BW-2:0], bin[i]};
      end
      return acc;
   endfunction

   // Combinational conversion of the current input value.
   always_comb begin
      bcd_s = double_dabble(a);
   end

`ifdef BINARY_TO_BCD_HANDSHAKE_EN
   // Output register: loads on in_valid, holds otherwise; out_valid tracks in_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b         <= {BW{1'b0}};
         out_valid <= 1'b0;
      end else begin
         if (in_valid) begin
            b <= bcd_s;
         end else begin
            b <= b;
         end
         out_valid <= in_valid;
      end
   end
`else
   // Output register: loads the conversion of a on every rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b <= {BW{1'b0}};
      end else begin
         b <= bcd_s;
      end
   end
`endif

endmodule

// File: tb/tb_binary_to_bcd.sv
// tb_binary_to_bcd: scoreboard bench for binary_to_bcd (WIDTH=8, DIGITS=3).
// Inputs change on the falling edge; outputs are read on the falling edge,
// one full cycle after the rising edge that captured them.
// Build with BINARY_TO_BCD_HANDSHAKE_EN defined to also cover the handshake ports.
module tb_binary_to_bcd;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  a;
   logic [11:0] b;
`ifdef BINARY_TO_BCD_HANDSHAKE_EN
   logic        in_valid;
   logic        out_valid;
`endif

   int checks = 0;
   int errors = 0;
   logic [11:0] exp_q[$];

   always #5 clk = ~clk;

   binary_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef BINARY_TO_BCD_HANDSHAKE_EN
      .in_valid (in_valid),
      .out_valid(out_valid),
`endif
      .a        (a),
      .b        (b)
   );

   // Reference conversion by decimal division, independent of double-dabble.
   function automatic logic [11:0] ref_bcd(input logic [7:0] v);
      int n;
      n = int'(v);
      return 12'((n % 10) | (((n / 10) % 10) << 4) | ((n / 100) << 8));
   endfunction

   task automatic drive_push(input logic [7:0] v, input logic [11:0] e);
      a = v;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      a     = 8'd200;
`ifdef BINARY_TO_BCD_HANDSHAKE_EN
      in_valid = 1'b1;
`endif
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (b !== 12'h000) begin
         errors++;
         $display("FAIL reset_immediate: b=%03h expected 000", b);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (b !== 12'h000) begin
            errors++;
            $display("FAIL reset_held[%0d]: b=%03h expected 000", i, b);
         end
`ifdef BINARY_TO_BCD_HANDSHAKE_EN
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid[%0d]: out_valid=%0b expected 0", i, out_valid);
         end
`endif
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (b !== 12'h200) begin
         errors++;
         $display("FAIL reset_first_update: b=%03h expected 200", b);
      end
   endtask

   task automatic test_constants(input string name, input logic [7:0] vals[4], input logic [11:0] exps[4], input int n);
      logic [11:0] e;
      exp_q.delete();
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (b !== e) begin
               errors++;
               $display("FAIL %s[%0d]: b=%03h expected %03h", name, i - 1, b, e);
            end
         end
         if (i < n) drive_push(vals[i], exps[i]);
      end
   endtask

   task automatic test_digit_boundaries();
      logic [7:0]  vals[4];
      logic [11:0] exps[4];
      vals = '{8'd9, 8'd10, 8'd99, 8'd100};
      exps = '{12'h009, 12'h010, 12'h099, 12'h100};
      test_constants("digit_boundary", vals, exps, 4);
   endtask

   task automatic test_extremes();
      logic [7:0]  vals[4];
      logic [11:0] exps[4];
      vals = '{8'd0, 8'd255, 8'd0, 8'd255};
      exps = '{12'h000, 12'h255, 12'h000, 12'h255};
      test_constants("extreme", vals, exps, 4);
   endtask

   task automatic test_sweep();
      logic [11:0] e;
      exp_q.delete();
      for (int v = 0; v <= 256; v++) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (b !== e) begin
               errors++;
               $display("FAIL sweep a=%0d: b=%03h expected %03h", v - 1, b, e);
            end
            for (int k = 0; k < DIGITS; k++) begin
               checks++;
               if (b[4*k +: 4] > 4'd9) begin
                  errors++;
                  $display("FAIL sweep_nibble a=%0d digit %0d: nibble=%0d expected <=9", v - 1, k, b[4*k +: 4]);
               end
            end
`ifdef BINARY_TO_BCD_HANDSHAKE_EN
            checks++;
            if (out_valid !== 1'b1) begin
               errors++;
               $display("FAIL sweep_out_valid a=%0d: out_valid=%0b expected 1", v - 1, out_valid);
            end
`endif
         end
         if (v < 256) drive_push(8'(v), ref_bcd(8'(v)));
      end
   endtask

   task automatic test_reset_midstream();
      logic [11:0] e;
      logic [7:0]  r;
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (b !== e) begin
               errors++;
               $display("FAIL midstream_pre[%0d]: b=%03h expected %03h", i, b, e);
            end
         end
         r = 8'($urandom_range(255, 0));
         drive_push(r, ref_bcd(r));
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      checks++;
      if (b !== 12'h000) begin
         errors++;
         $display("FAIL midstream_reset: b=%03h expected 000", b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_push(8'd37, 12'h037);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (b !== e) begin
         errors++;
         $display("FAIL midstream_release: b=%03h expected %03h", b, e);
      end
   endtask

`ifdef BINARY_TO_BCD_HANDSHAKE_EN
   task automatic test_handshake();
      @(negedge clk);
      in_valid = 1'b1;
      a        = 8'd123;
      @(negedge clk);
      checks++;
      if (b !== 12'h123 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL handshake_load: b=%03h out_valid=%0b expected 123/1", b, out_valid);
      end
      in_valid = 1'b0;
      a        = 8'd45;
      @(negedge clk);
      checks++;
      if (b !== 12'h123 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL handshake_hold: b=%03h out_valid=%0b expected 123/0", b, out_valid);
      end
      in_valid = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_digit_boundaries();
      test_extremes();
      test_sweep();
      test_reset_midstream();
`ifdef BINARY_TO_BCD_HANDSHAKE_EN
      test_handshake();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
